// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: piece codes, win-check controller states and scan sizing.
package connect4_pkg;

  localparam logic [1:0] PIECE_NONE = 2'b00;
  localparam logic [1:0] PIECE_BLUE = 2'b01;
  localparam logic [1:0] PIECE_RED  = 2'b10;

  localparam int SEQ_PIECES   = 226;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_W        = 8;
  localparam int SCAN_LAST    = SEQ_PIECES + FLUSH_CYCLES - 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_REPORT = 3'd3,
    ST_OVER   = 3'd4
  } ctrl_state_t;

  // 2'b11 from the recognizer is illegal and must never count as a win.
  function automatic logic is_win_code(input logic [1:0] code);
    return (code == PIECE_BLUE) || (code == PIECE_RED);
  endfunction

endpackage

// File: rtl/win_check_controller_scan_counter.sv
// Scan-window counter: cleared on reload, counts while enabled, flags the last window cycle.
module scan_counter #(
  parameter int CNT_W = 8,
  parameter int LAST  = 227
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] cnt_reg;

  if ((2 ** CNT_W) <= (LAST + 1)) begin : g_width_check
    $fatal(1, "scan_counter: CNT_W too narrow for LAST");
  end

  // Holding at LAST keeps the counter from ever wrapping.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_reg <= '0;
    end else if (enable && !last) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign last = (cnt_reg == CNT_W'(LAST));

endmodule

// File: rtl/win_check_controller.sv
// Sequences the four-in-a-row recognizer after each drop and latches the winner/draw outcome.
module win_check_controller
  import connect4_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       new_game,
  input  logic       board_full,
  input  logic [1:0] detect_in,
  output logic       check_enable,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner,
  output logic       draw,
  output logic       game_over
);

  ctrl_state_t state;
  logic        scan_last;

  scan_counter #(
    .CNT_W (CNT_W),
    .LAST  (SCAN_LAST)
  ) u_scan_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == ST_LOAD),
    .enable (state == ST_SCAN),
    .last   (scan_last)
  );

  // Outputs are registered together with the state so they change on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      check_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      winner       <= PIECE_NONE;
      draw         <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          state        <= ST_SCAN;
          check_enable <= 1'b1;
        end
        ST_SCAN: begin
          // A win on the terminal cycle still wins over the timeout.
          if (is_win_code(detect_in)) begin
            winner       <= detect_in;
            state        <= ST_REPORT;
            check_enable <= 1'b0;
            done         <= 1'b1;
          end else if (scan_last) begin
            state        <= ST_REPORT;
            check_enable <= 1'b0;
            done         <= 1'b1;
          end
        end
        ST_REPORT: begin
          draw <= board_full && (winner == PIECE_NONE);
          busy <= 1'b0;
          if ((winner != PIECE_NONE) || board_full) begin
            state     <= ST_OVER;
            game_over <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_OVER: begin
          if (new_game) begin
            state     <= ST_IDLE;
            winner    <= PIECE_NONE;
            draw      <= 1'b0;
            game_over <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          check_enable <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_win_check_controller.sv
// Scoreboard bench for win_check_controller: random scans against a rule-level outcome model.
module tb_win_check_controller;

  localparam int WINDOW = 228;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       new_game = 1'b0;
  logic       board_full = 1'b0;
  logic [1:0] detect_in = 2'b00;
  logic       check_enable, busy, done, draw, game_over;
  logic [1:0] winner;

  win_check_controller dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .new_game     (new_game),
    .board_full   (board_full),
    .detect_in    (detect_in),
    .check_enable (check_enable),
    .busy         (busy),
    .done         (done),
    .winner       (winner),
    .draw         (draw),
    .game_over    (game_over)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         len;
    logic [1:0] win;
    logic       drw;
    logic       over;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  int   en_cnt = 0;
  bit   pend   = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: counts enable cycles per scan, checks each done pulse against the queue.
  always @(negedge clock) begin
    if (reset) begin
      en_cnt = 0;
      pend   = 0;
    end else begin
      if (pend) begin
        chk("draw", int'(draw), int'(cur.drw));
        chk("game_over", int'(game_over), int'(cur.over));
        pend = 0;
      end
      if (check_enable) en_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("scan_len", en_cnt, cur.len);
          chk("winner", int'(winner), int'(cur.win));
          chk("busy_in_report", int'(busy), 1);
          pend = 1;
        end
        en_cnt = 0;
        $display("txn: scan_len=%0d winner=%0d", cur.len, winner);
      end
    end
  end

  // Reference: a win at scan cycle k ends the window after k+1 cycles, otherwise it runs its full length.
  function automatic exp_t model(input int k, input logic [1:0] code, input logic full);
    exp_t e;
    if (k >= 0 && k < WINDOW && (code == 2'b01 || code == 2'b10)) begin
      e.len = k + 1;
      e.win = code;
    end else begin
      e.len = WINDOW;
      e.win = 2'b00;
    end
    e.drw  = full && (e.win == 2'b00);
    e.over = (e.win != 2'b00) || full;
    return e;
  endfunction

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  // k < 0 means no win is driven; non-win cycles carry random 00/11 noise.
  task automatic run_scan(input int k, input logic [1:0] code, input logic full);
    exp_t e;
    e = model(k, code, full);
    exp_q.push_back(e);
    board_full = full;
    pulse_start();
    for (int i = 0; i < WINDOW; i++) begin
      @(negedge clock);
      if (i == k) detect_in = code;
      else detect_in = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
    end
    @(negedge clock); detect_in = 2'b00;
    repeat (3) @(negedge clock);
    chk("busy_after", int'(busy), 0);
    chk("check_enable_after", int'(check_enable), 0);
    if (e.over) begin
      pulse_start();
      repeat (3) @(negedge clock);
      chk("over_ignores_start", int'({game_over, busy, check_enable}), 3'b100);
      chk("winner_held", int'(winner), int'(e.win));
      @(negedge clock); new_game = 1'b1;
      @(negedge clock); new_game = 1'b0;
      chk("new_game_clears", int'({game_over, winner, draw}), 0);
    end else begin
      chk("idle_after_scan", int'({game_over, winner, draw}), 0);
    end
    board_full = 1'b0;
  endtask

  task automatic abort_scan(input int at);
    pulse_start();
    for (int i = 0; i <= at; i++) begin
      @(negedge clock); detect_in = 2'b00;
    end
    reset = 1'b1;
    @(negedge clock);
    chk("reset_mid_scan", int'({check_enable, busy, done, winner, draw, game_over}), 0);
    @(negedge clock); reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("reset_idle", int'({check_enable, busy, done, winner, draw, game_over}), 0);
    end
    run_scan(-1, 2'b00, 1'b0);
    run_scan(40, 2'b01, 1'b0);
    run_scan(227, 2'b10, 1'b0);
    run_scan(-1, 2'b00, 1'b1);
    abort_scan(100);
    run_scan(-1, 2'b00, 1'b0);
    run_scan(0, 2'b10, 1'b1);
    for (int n = 0; n < 8; n++) begin
      int k;
      k = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, WINDOW - 1));
      run_scan(k, ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, 1'($urandom_range(0, 1)));
    end
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
